pwm_wfg_core: RTL and testbench
===============================

# pwm_wfg_core

Single-channel PWM / waveform generator on the peripheral register bus. It counts either mclk cycles or the 1 µs / 1 ms tick pulses produced by the timer block. It drives a PWM output with double-buffered period and compare registers, a one-shot mode and a period-end interrupt. The peripheral wrapper instantiates one copy per PWM channel and decodes its chip-select from the block-select address bits.

## Interface
- No parameters; counter width fixed at 16 bits.
- mclk  in  1  system clock
- reset_ssn  in  1  reset, asynchronous, active-low
- pulse_1us  in  1  1 µs tick, one mclk cycle wide, from timer
- pulse_1ms  in  1  1 ms tick, one mclk cycle wide, from timer
- reg_cs  in  1  register chip-select, held by the host until reg_ack
- reg_wr  in  1  1 = write, 0 = read
- reg_addr  in  2  word address (bus addr[3:2])
- reg_wdata  in  32  write data
- reg_be  in  4  byte enables, writes only
- reg_rdata  out  32  read data, valid while reg_ack = 1
- reg_ack  out  1  single-cycle acknowledge
- pwm_out  out  1  PWM output
- pwm_out_n  out  1  complementary output
- pwm_intr  out  1  level interrupt

## Operation
- Register map (byte-enable qualified):
  - 0 CTRL:
    - [0] enable
    - [2:1] tick_sel: 0 = mclk, 1 = pulse_1us, 2 = pulse_1ms, 3 = no tick (counter frozen)
    - [3] one_shot
    - [4] polarity (1 = inverted)
    - [5] intr_en
    - [15:8] deadtime
  - 1 PERIOD: [15:0] shadow period; cycle length is period+1 ticks.
  - 2 COMPARE: [15:0] shadow compare.
  - 3 STATUS:
    - [0] intr_sts, write-1-to-clear
    - [1] running, RO
    - [31:16] current count, RO
- Reset values: CTRL = 0, PERIOD = 0xFFFF, COMPARE = 0, STATUS = 0.
- Active period/compare copies load from the shadows at two points:
  - on the IDLE→RUN transition
  - on each period-end tick
- FSM states:
  - IDLE: cnt = 0, output at idle level. Goes to RUN the cycle after enable is written 1.
  - RUN: on each selected tick:
    - if cnt == period_act: cnt ← 0, reload actives, set intr_sts. If one_shot, clear CTRL.enable and go to IDLE.
    - else cnt ← cnt+1.
  - Software writing enable = 0 in RUN forces IDLE the next cycle with cnt ← 0. No interrupt is raised.
- Waveform: raw = RUN && (cnt < cmp_act).
  - compare = 0 gives constant inactive.
  - compare > period gives constant active.
- pwm_out is raw XOR polarity, registered. In IDLE it equals polarity.
- pwm_intr = intr_sts & intr_en.
- Simultaneous hardware set and software W1C of intr_sts: the set wins.
- tick_sel change mid-run takes effect on the next cycle; cnt is not cleared.

## Timing
- reg_ack rises one cycle after reg_cs is seen with reg_ack low, stays high for exactly one cycle, and is 0 out of reset.
  - Back-to-back accesses therefore take at least 2 cycles each.
- Writes update registers at the ack edge.
- Reads return values sampled in the ack cycle.
- Enable write to first count: enable is written at ack edge T, RUN is entered at T+1 with cnt = 0, and pwm_out reflects cnt = 0 at T+2.
- pwm_out lags cnt by one mclk.
- Period-end: at the tick where cnt == period_act, intr_sts is set one cycle later and pwm_intr follows combinationally from it.
- Reset values: pwm_out = 0, pwm_out_n = 1, pwm_intr = 0, reg_rdata = 0.
- Reset asserted mid-run immediately forces all outputs and registers to reset values.

## Configuration
- PWM_DEADTIME_EN defined:
  - pwm_out_n is the complement of pwm_out with dead-band insertion.
  - On every raw edge, both outputs are held at their inactive level (polarity-adjusted) for deadtime mclk cycles before the newly active output asserts.
  - deadtime = 0 means no gap.
  - A pulse shorter than deadtime keeps both outputs inactive.
- PWM_DEADTIME_EN undefined:
  - pwm_out_n = ~pwm_out with no gap.
  - CTRL[15:8] is not stored and reads 0.

## Test plan
- Reset, then read all 4 registers → CTRL = 0, PERIOD = 0x0000FFFF, COMPARE = 0, STATUS = 0; pwm_out = 0, pwm_intr = 0.
- PERIOD = 9, COMPARE = 3, tick_sel = 0, enable = 1 → pwm_out high 3 mclk, low 7, repeating every 10 mclk; intr_sts set every 10 cycles.
- tick_sel = 1 with a 1-cycle pulse_1us every 50 mclk, PERIOD = 4, COMPARE = 2, one_shot = 1, intr_en = 1 → pwm_out high for 100 mclk then low, with exactly one period (250 mclk). pwm_intr then asserts, enable reads 0 and running reads 0.
- Write COMPARE = 8 mid-period (PERIOD = 9, COMPARE = 3) → the current period keeps 3 high cycles, and the next period shows 8 high cycles.
- At a period-end cycle, write STATUS = 1 while intr_sts is already set → intr_sts remains 1; a second W1C clears it.
- With PWM_DEADTIME_EN, deadtime = 2, PERIOD = 9, COMPARE = 5 → both outputs are low for 2 mclk at each transition, and pwm_out and pwm_out_n are never simultaneously high.

Source files
------------

// File: rtl/pwm_wfg_core.sv
// Single-channel PWM/waveform generator with double-buffered period/compare, one-shot mode and period-end interrupt.
// Optional dead-band insertion on the complementary output is built when PWM_DEADTIME_EN is defined.
module pwm_wfg_core (
  input  logic        mclk,
  input  logic        reset_ssn,
  input  logic        pulse_1us,
  input  logic        pulse_1ms,
  input  logic        reg_cs,
  input  logic        reg_wr,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic [3:0]  reg_be,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        pwm_out,
  output logic        pwm_out_n,
  output logic        pwm_intr
);

  // Bus handshake: an access is taken on the edge where reg_cs is high and reg_ack_q is low;
  // that edge raises reg_ack for exactly one cycle, commits writes and captures read data.
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        enable_q, one_shot_q, polarity_q, intr_en_q;
  logic [1:0]  tick_sel_q;
  logic [15:0] period_sh_q, cmp_sh_q, period_act_q, cmp_act_q;
  logic [15:0] cnt_q, cnt_d;
  logic        intr_sts_q;
  logic        ack_q;
  logic [31:0] rdata_q, rd_val;
  logic [7:0]  deadtime_rd;
  logic        access, wr_en, rd_en, w1c;
  logic        tick, load_act, period_end, raw;
  logic        unused_bits;

  assign access = reg_cs & ~ack_q;
  assign wr_en  = access & reg_wr;
  assign rd_en  = access & ~reg_wr;
  assign w1c    = wr_en && (reg_addr == 2'd3) && reg_be[0] && reg_wdata[0];
  assign unused_bits = ^{reg_wdata[31:16], reg_be[3:2]};

  always_comb begin
    tick = 1'b0;
    case (tick_sel_q)
      2'd0:    tick = 1'b1;
      2'd1:    tick = pulse_1us;
      2'd2:    tick = pulse_1ms;
      default: tick = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_act   = 1'b0;
    period_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'h0000;
        if (enable_q) begin
          state_d  = ST_RUN;
          load_act = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
          cnt_d   = 16'h0000;
        end else if (tick) begin
          if (cnt_q == period_act_q) begin
            cnt_d      = 16'h0000;
            load_act   = 1'b1;
            period_end = 1'b1;
            if (one_shot_q) state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'h0000;
      enable_q     <= 1'b0;
      tick_sel_q   <= 2'd0;
      one_shot_q   <= 1'b0;
      polarity_q   <= 1'b0;
      intr_en_q    <= 1'b0;
      period_sh_q  <= 16'hFFFF;
      cmp_sh_q     <= 16'h0000;
      period_act_q <= 16'hFFFF;
      cmp_act_q    <= 16'h0000;
      intr_sts_q   <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= access;
      rdata_q <= rd_en ? rd_val : 32'h0;
      if (wr_en && reg_addr == 2'd0 && reg_be[0]) begin
        enable_q   <= reg_wdata[0];
        tick_sel_q <= reg_wdata[2:1];
        one_shot_q <= reg_wdata[3];
        polarity_q <= reg_wdata[4];
        intr_en_q  <= reg_wdata[5];
      end
      // One-shot completion overrides a coincident software enable write.
      if (period_end && one_shot_q) enable_q <= 1'b0;
      if (wr_en && reg_addr == 2'd1) begin
        if (reg_be[0]) period_sh_q[7:0]  <= reg_wdata[7:0];
        if (reg_be[1]) period_sh_q[15:8] <= reg_wdata[15:8];
      end
      if (wr_en && reg_addr == 2'd2) begin
        if (reg_be[0]) cmp_sh_q[7:0]  <= reg_wdata[7:0];
        if (reg_be[1]) cmp_sh_q[15:8] <= reg_wdata[15:8];
      end
      if (load_act) begin
        period_act_q <= period_sh_q;
        cmp_act_q    <= cmp_sh_q;
      end
      if (period_end)  intr_sts_q <= 1'b1;
      else if (w1c)    intr_sts_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = 32'h0;
    case (reg_addr)
      2'd0:    rd_val = {16'h0, deadtime_rd, 2'b00, intr_en_q, polarity_q, one_shot_q, tick_sel_q, enable_q};
      2'd1:    rd_val = {16'h0, period_sh_q};
      2'd2:    rd_val = {16'h0, cmp_sh_q};
      default: rd_val = {cnt_q, 14'h0, (state_q == ST_RUN), intr_sts_q};
    endcase
  end

  assign raw       = (state_q == ST_RUN) && (cnt_q < cmp_act_q);
  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign pwm_intr  = intr_sts_q & intr_en_q;

`ifdef PWM_DEADTIME_EN
  logic [7:0] deadtime_q, dt_q, dt_d;
  logic       raw_q, p_on_q, n_on_q, p_on_d, n_on_d;

  always_ff @(posedge mclk or negedge reset_ssn) begin
    if (!reset_ssn) deadtime_q <= 8'h00;
    else if (wr_en && reg_addr == 2'd0 && reg_be[1]) deadtime_q <= reg_wdata[15:8];
  end

  // Any raw edge (re)starts the gap, so a pulse shorter than the gap never reaches either output.
  always_comb begin
    dt_d   = dt_q;
    p_on_d = raw;
    n_on_d = ~raw;
    if (raw != raw_q) begin
      dt_d = deadtime_q;
      if (deadtime_q != 8'h00) begin
        p_on_d = 1'b0;
        n_on_d = 1'b0;
      end
    end else if (dt_q != 8'h00) begin
      dt_d = dt_q - 8'd1;
      if (dt_q != 8'd1) begin
        p_on_d = 1'b0;
        n_on_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      raw_q  <= 1'b0;
      dt_q   <= 8'h00;
      p_on_q <= 1'b0;
      n_on_q <= 1'b1;
    end else begin
      raw_q  <= raw;
      dt_q   <= dt_d;
      p_on_q <= p_on_d;
      n_on_q <= n_on_d;
    end
  end

  assign deadtime_rd = deadtime_q;
  assign pwm_out     = p_on_q ^ polarity_q;
  assign pwm_out_n   = n_on_q ^ polarity_q;
`else
  logic pwm_q;

  always_ff @(posedge mclk or negedge reset_ssn) begin
    if (!reset_ssn) pwm_q <= 1'b0;
    else            pwm_q <= raw ^ polarity_q;
  end

  assign deadtime_rd = 8'h00;
  assign pwm_out     = pwm_q;
  assign pwm_out_n   = ~pwm_q;
`endif

endmodule

// File: tb/tb_pwm_wfg_core.sv
// Self-checking bench for pwm_wfg_core: bus driver tasks, per-cycle output history and an arithmetic waveform model.
`timescale 1ns/1ps
module tb_pwm_wfg_core;
  logic        mclk = 1'b0, reset_ssn = 1'b0, pulse_1us = 1'b0, pulse_1ms = 1'b0;
  logic        reg_cs = 1'b0, reg_wr = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'h0;
  logic [3:0]  reg_be = 4'h0;
  logic [31:0] reg_rdata;
  logic        reg_ack, pwm_out, pwm_out_n, pwm_intr;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  logic hist_p[4096], hist_n[4096], hist_i[4096];
  logic us_gen_en = 1'b0;

  pwm_wfg_core dut (
    .mclk(mclk), .reset_ssn(reset_ssn), .pulse_1us(pulse_1us), .pulse_1ms(pulse_1ms),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .pwm_out(pwm_out), .pwm_out_n(pwm_out_n), .pwm_intr(pwm_intr)
  );

  // ---------------- clock / history / tick generator ----------------
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;
  // hist_x[n] holds the output as it stands after the n-th rising edge.
  always @(negedge mclk) begin
    if (cyc < 4096) begin
      hist_p[cyc] = pwm_out;
      hist_n[cyc] = pwm_out_n;
      hist_i[cyc] = pwm_intr;
    end
    pulse_1us = us_gen_en && (((cyc + 1) % 50) == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge mclk); #1;
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be, output int ack_cyc);
    int waited;
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = be;
    waited = 0; ack_cyc = -1;
    while (ack_cyc < 0 && waited < 8) begin
      @(posedge mclk); #1; waited++;
      if (reg_ack === 1'b1) ack_cyc = cyc;
    end
    n_checks++;
    if (ack_cyc < 0) begin
      $display("FAIL bus_write_ack addr=%0d: reg_ack stayed low, required high within 8 cycles", a);
      n_fail++;
    end
    reg_cs = 1'b0; reg_wr = 1'b0; reg_be = 4'h0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d, output int ack_cyc);
    int waited;
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a; reg_be = 4'h0;
    waited = 0; ack_cyc = -1; d = 32'hx;
    while (ack_cyc < 0 && waited < 8) begin
      @(posedge mclk); #1; waited++;
      if (reg_ack === 1'b1) begin
        ack_cyc = cyc;
        d = reg_rdata;
      end
    end
    n_checks++;
    if (ack_cyc < 0) begin
      $display("FAIL bus_read_ack addr=%0d: reg_ack stayed low, required high within 8 cycles", a);
      n_fail++;
    end
    reg_cs = 1'b0;
  endtask

  task automatic cleanup();
    int t;
    reg_write(2'd0, 32'h0, 4'hF, t);
    reg_write(2'd3, 32'h1, 4'h1, t);
    repeat (3) @(posedge mclk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rst [4];
    int t;
    exp_rst = '{32'h0, 32'h0000FFFF, 32'h0, 32'h0};
    reset_ssn = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    n_checks++; if (pwm_out !== 1'b0)   begin $display("FAIL rst_pwm_out got=%b exp=0", pwm_out); n_fail++; end
    n_checks++; if (pwm_out_n !== 1'b1) begin $display("FAIL rst_pwm_out_n got=%b exp=1", pwm_out_n); n_fail++; end
    n_checks++; if (pwm_intr !== 1'b0)  begin $display("FAIL rst_pwm_intr got=%b exp=0", pwm_intr); n_fail++; end
    n_checks++; if (reg_ack !== 1'b0)   begin $display("FAIL rst_reg_ack got=%b exp=0", reg_ack); n_fail++; end
    n_checks++; if (reg_rdata !== 32'h0) begin $display("FAIL rst_reg_rdata got=%h exp=0", reg_rdata); n_fail++; end
    @(negedge mclk);
    reset_ssn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      reg_read(a[1:0], d, t);
      n_checks++;
      if (d !== exp_rst[a]) begin $display("FAIL rst_reg%0d got=%h exp=%h", a, d, exp_rst[a]); n_fail++; end
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] d;
    logic [31:0] exp_ctrl;
    int t;
    reg_write(2'd1, 32'h0000_5634, 4'b0001, t);
    reg_read(2'd1, d, t);
    n_checks++; if (d !== 32'h0000_FF34) begin $display("FAIL be_period_lo got=%h exp=0000ff34", d); n_fail++; end
    reg_write(2'd1, 32'h0000_5600, 4'b0010, t);
    reg_read(2'd1, d, t);
    n_checks++; if (d !== 32'h0000_5634) begin $display("FAIL be_period_hi got=%h exp=00005634", d); n_fail++; end
    // enable left 0; tick_sel=2, one_shot, polarity, intr_en set
    reg_write(2'd0, 32'hFFFF_AB3C, 4'b0001, t);
    reg_read(2'd0, d, t);
    n_checks++; if (d !== 32'h0000_003C) begin $display("FAIL be_ctrl_lo got=%h exp=0000003c", d); n_fail++; end
    reg_write(2'd0, 32'h0000_AB00, 4'b0010, t);
    reg_read(2'd0, d, t);
`ifdef PWM_DEADTIME_EN
    exp_ctrl = 32'h0000_AB3C;
`else
    exp_ctrl = 32'h0000_003C;
`endif
    n_checks++; if (d !== exp_ctrl) begin $display("FAIL be_ctrl_deadtime got=%h exp=%h", d, exp_ctrl); n_fail++; end
    cleanup();
  endtask

  task automatic test_pwm_mclk(input int p, input int c, input logic pol);
    int t, tt, span, k;
    logic exp_p, exp_i;
    reg_write(2'd1, p, 4'h3, tt);
    reg_write(2'd2, c, 4'h3, tt);
    reg_write(2'd0, 32'h21 | (32'(pol) << 4), 4'hF, t);
    span = 3 * (p + 1) + 2;
    wait_until(t + 2 + span);
    for (int n = t + 1; n <= t + 1 + span; n++) begin
      k = n - t - 2;
      exp_p = ((k >= 0) && ((k % (p + 1)) < c)) ^ pol;
      exp_i = (n >= t + 2 + p);
      n_checks++;
      if (hist_p[n] !== exp_p) begin $display("FAIL pwm_out P=%0d C=%0d pol=%0d k=%0d got=%b exp=%b", p, c, pol, k, hist_p[n], exp_p); n_fail++; end
      n_checks++;
      if (hist_n[n] !== ~exp_p) begin $display("FAIL pwm_out_n P=%0d C=%0d k=%0d got=%b exp=%b", p, c, k, hist_n[n], ~exp_p); n_fail++; end
      n_checks++;
      if (hist_i[n] !== exp_i) begin $display("FAIL pwm_intr P=%0d C=%0d k=%0d got=%b exp=%b", p, c, k, hist_i[n], exp_i); n_fail++; end
    end
    cleanup();
  endtask

  task automatic test_one_shot();
    int t, tt, t1, t5, nticks;
    logic [31:0] d;
    logic exp_p, exp_i;
    reg_write(2'd1, 32'd4, 4'h3, tt);
    reg_write(2'd2, 32'd2, 4'h3, tt);
    us_gen_en = 1'b1;
    repeat ($urandom_range(0, 60)) @(posedge mclk);
    #1;
    reg_write(2'd0, 32'h2B, 4'hF, t);
    t1 = ((t + 2 + 49) / 50) * 50;
    t5 = t1 + 200;
    wait_until(t5 + 62);
    for (int n = t + 1; n <= t5 + 60; n++) begin
      nticks = 0;
      for (int m = t1; m < n; m += 50) nticks++;
      exp_p = (n >= t + 2) && (n <= t5) && (nticks < 2);
      exp_i = (n >= t5);
      n_checks++;
      if (hist_p[n] !== exp_p) begin $display("FAIL oneshot_pwm n-T=%0d got=%b exp=%b", n - t, hist_p[n], exp_p); n_fail++; end
      n_checks++;
      if (hist_i[n] !== exp_i) begin $display("FAIL oneshot_intr n-T=%0d got=%b exp=%b", n - t, hist_i[n], exp_i); n_fail++; end
    end
    reg_read(2'd0, d, tt);
    n_checks++; if (d !== 32'h0000_002A) begin $display("FAIL oneshot_ctrl got=%h exp=0000002a", d); n_fail++; end
    reg_read(2'd3, d, tt);
    n_checks++; if (d !== 32'h0000_0001) begin $display("FAIL oneshot_status got=%h exp=00000001", d); n_fail++; end
    us_gen_en = 1'b0;
    cleanup();
  endtask

  task automatic test_compare_update();
    int t, tc, tt, k, j, cmp;
    logic exp_p;
    reg_write(2'd1, 32'd9, 4'h3, tt);
    reg_write(2'd2, 32'd3, 4'h3, tt);
    reg_write(2'd0, 32'h01, 4'hF, t);
    wait_until(t + $urandom_range(1, 7));
    reg_write(2'd2, 32'd8, 4'h3, tc);
    wait_until(t + 33);
    for (int n = t + 2; n <= t + 31; n++) begin
      k = n - t - 2;
      j = k / 10;
      cmp = (tc < t + 1 + j * 10) ? 8 : 3;
      exp_p = (k % 10) < cmp;
      n_checks++;
      if (hist_p[n] !== exp_p) begin $display("FAIL cmp_update k=%0d wr_at=%0d got=%b exp=%b", k, tc - t, hist_p[n], exp_p); n_fail++; end
    end
    cleanup();
  endtask

  task automatic test_intr_w1c();
    int t, tw, tr, tc, tt, cnt;
    logic [31:0] d, exp_d;
    reg_write(2'd1, 32'd9, 4'h3, tt);
    reg_write(2'd2, 32'd3, 4'h3, tt);
    reg_write(2'd0, 32'h21, 4'hF, t);
    // second period end lands on edge T+21; aim the W1C at that edge
    wait_until(t + 20);
    reg_write(2'd3, 32'h1, 4'h1, tw);
    n_checks++; if (tw !== t + 21) begin $display("FAIL w1c_ack_edge got=T+%0d exp=T+21", tw - t); n_fail++; end
    n_checks++; if (pwm_intr !== 1'b1) begin $display("FAIL w1c_set_wins got=%b exp=1", pwm_intr); n_fail++; end
    reg_read(2'd3, d, tr);
    cnt = (tr - 1 - (t + 1)) % 10;
    exp_d = (32'(cnt) << 16) | 32'h3;
    n_checks++; if (d !== exp_d) begin $display("FAIL w1c_status got=%h exp=%h", d, exp_d); n_fail++; end
    reg_write(2'd3, 32'h1, 4'h1, tc);
    n_checks++; if (pwm_intr !== 1'b0) begin $display("FAIL w1c_clear got=%b exp=0", pwm_intr); n_fail++; end
    for (int n = t + 1; n < tc; n++) begin
      n_checks++;
      if (hist_i[n] !== (n >= t + 11)) begin $display("FAIL w1c_hist n-T=%0d got=%b exp=%b", n - t, hist_i[n], (n >= t + 11)); n_fail++; end
    end
    cleanup();
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    int t, tt, kk;
    logic r, exp_p, exp_n;
    reg_write(2'd1, 32'd9, 4'h3, tt);
    reg_write(2'd2, 32'd5, 4'h3, tt);
    reg_write(2'd0, 32'h0201, 4'hF, t);
    wait_until(t + 33);
    for (int n = t + 1; n <= t + 31; n++) begin
      exp_p = 1'b1; exp_n = 1'b1;
      for (int w = 0; w < 3; w++) begin
        kk = n - t - 2 - w;
        r = (kk >= 0) && ((kk % 10) < 5);
        exp_p &= r;
        exp_n &= ~r;
      end
      n_checks++;
      if (hist_p[n] !== exp_p) begin $display("FAIL dt_pwm_out n-T=%0d got=%b exp=%b", n - t, hist_p[n], exp_p); n_fail++; end
      n_checks++;
      if (hist_n[n] !== exp_n) begin $display("FAIL dt_pwm_out_n n-T=%0d got=%b exp=%b", n - t, hist_n[n], exp_n); n_fail++; end
      n_checks++;
      if ((hist_p[n] & hist_n[n]) !== 1'b0) begin $display("FAIL dt_overlap n-T=%0d got=1 exp=0", n - t); n_fail++; end
    end
    cleanup();
  endtask
`endif

  task automatic test_reset_mid_run();
    int t, tt;
    logic [31:0] d;
    reg_write(2'd1, 32'd3, 4'h3, tt);
    reg_write(2'd2, 32'd15, 4'h3, tt);
    reg_write(2'd0, 32'h21, 4'hF, t);
    wait_until(t + 10);
    n_checks++; if (pwm_out !== 1'b1)  begin $display("FAIL midrst_pre_pwm got=%b exp=1", pwm_out); n_fail++; end
    n_checks++; if (pwm_intr !== 1'b1) begin $display("FAIL midrst_pre_intr got=%b exp=1", pwm_intr); n_fail++; end
    #2 reset_ssn = 1'b0;
    #1;
    n_checks++; if (pwm_out !== 1'b0)   begin $display("FAIL midrst_pwm_out got=%b exp=0", pwm_out); n_fail++; end
    n_checks++; if (pwm_out_n !== 1'b1) begin $display("FAIL midrst_pwm_out_n got=%b exp=1", pwm_out_n); n_fail++; end
    n_checks++; if (pwm_intr !== 1'b0)  begin $display("FAIL midrst_pwm_intr got=%b exp=0", pwm_intr); n_fail++; end
    @(negedge mclk);
    reset_ssn = 1'b1;
    reg_read(2'd1, d, tt);
    n_checks++; if (d !== 32'h0000_FFFF) begin $display("FAIL midrst_period got=%h exp=0000ffff", d); n_fail++; end
    reg_read(2'd3, d, tt);
    n_checks++; if (d !== 32'h0) begin $display("FAIL midrst_status got=%h exp=00000000", d); n_fail++; end
    reg_read(2'd0, d, tt);
    n_checks++; if (d !== 32'h0) begin $display("FAIL midrst_ctrl got=%h exp=00000000", d); n_fail++; end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    int p, c;
    test_reset();
    test_byte_enables();
    test_pwm_mclk(9, 3, 1'b0);
    test_pwm_mclk(4, 0, 1'b1);
    test_pwm_mclk(3, 7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      p = $urandom_range(1, 12);
      c = $urandom_range(0, p + 2);
      test_pwm_mclk(p, c, 1'($urandom_range(0, 1)));
    end
    test_one_shot();
    test_compare_update();
    test_intr_w1c();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
